// File: rtl/register_file.sv
// Dual-bank (integer / floating-point) register file: two combinational read
// ports, one clocked write port, index 0 of each bank reads as zero.
module register_file #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] readReg1,
    input  logic [ADDR_W-1:0] readReg2,
    input  logic [ADDR_W-1:0] writeReg,
    input  logic [WIDTH-1:0]  writeData,
    input  logic              regWrite,
    input  logic              float,
    output logic [WIDTH-1:0]  dataOut1,
    output logic [WIDTH-1:0]  dataOut2
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0][WIDTH-1:0] intRegs;
    logic [DEPTH-1:0][WIDTH-1:0] fpRegs;
    logic                        wrEn;

    // Index 0 is never written, so its storage stays at the reset value of zero.
    assign wrEn = regWrite && (writeReg != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            intRegs <= '0;
            fpRegs  <= '0;
        end else if (wrEn) begin
            if (float) fpRegs[writeReg]  <= writeData;
            else       intRegs[writeReg] <= writeData;
        end
    end

    // Explicit zero on index 0 keeps the hardwired-zero property local to the read mux.
    always_comb begin
        dataOut1 = '0;
        dataOut2 = '0;
        if (readReg1 != '0) dataOut1 = float ? fpRegs[readReg1] : intRegs[readReg1];
        if (readReg2 != '0) dataOut2 = float ? fpRegs[readReg2] : intRegs[readReg2];
    end
endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: directed literal checks plus randomized traffic
// compared every cycle against an array-based model of both banks.
module tb_register_file;
    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  readReg1, readReg2, writeReg;
    logic [31:0] writeData;
    logic        regWrite, float;
    logic [31:0] dataOut1, dataOut2;

    int nCmp = 0;
    int nBad = 0;

    logic [31:0] intM [32];
    logic [31:0] fpM  [32];

    register_file #(.WIDTH(32), .ADDR_W(5)) dut (
        .clk(clk), .reset(reset),
        .readReg1(readReg1), .readReg2(readReg2),
        .writeReg(writeReg), .writeData(writeData),
        .regWrite(regWrite), .float(float),
        .dataOut1(dataOut1), .dataOut2(dataOut2)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 32; i++) begin
            intM[i] = '0;
            fpM[i]  = '0;
        end
    end

    // Model: registers as plain arrays, updated by the architectural write rule.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                intM[i] = '0;
                fpM[i]  = '0;
            end
        end else if (regWrite === 1'b1 && writeReg != 5'd0) begin
            if (float) fpM[writeReg] = writeData;
            else       intM[writeReg] = writeData;
        end
    end

    function automatic logic [31:0] expRead(input logic f, input logic [4:0] idx);
        if (reset || idx == 5'd0) return 32'h0;
        return f ? fpM[idx] : intM[idx];
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        nCmp++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        check("port1_vs_model", dataOut1, expRead(float, readReg1));
        check("port2_vs_model", dataOut2, expRead(float, readReg2));
    end

    task automatic drive(input logic f, input logic we, input logic [4:0] wr,
                         input logic [31:0] wd, input logic [4:0] r1, input logic [4:0] r2);
        float = f; regWrite = we; writeReg = wr; writeData = wd;
        readReg1 = r1; readReg2 = r2;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 1, 2);
        #3;
        check("reset_p1", dataOut1, 32'h0);
        check("reset_p2", dataOut2, 32'h0);
        #5 reset = 1'b0;   // t=8, between edges
        tick;

        drive(0, 1, 1, 32'h0000002c, 1, 2);
        #1;
        check("pre_edge_p1", dataOut1, 32'h0);
        check("pre_edge_p2", dataOut2, 32'h0);
        tick;
        check("int1_p1", dataOut1, 32'h0000002c);
        check("int1_p2", dataOut2, 32'h0);

        drive(0, 1, 2, 32'hffffffff, 1, 2);
        tick;
        check("int2_p1", dataOut1, 32'h0000002c);
        check("int2_p2", dataOut2, 32'hffffffff);

        drive(0, 1, 0, 32'hffffffff, 0, 2);
        tick;
        check("int0_p1", dataOut1, 32'h0);
        check("int0_p2", dataOut2, 32'hffffffff);

        drive(1, 1, 1, 32'hf0f0f0f0, 1, 2);
        tick;
        check("fp1_p1", dataOut1, 32'hf0f0f0f0);
        check("fp1_p2", dataOut2, 32'h0);

        drive(1, 1, 0, 32'hffffffff, 0, 1);
        tick;
        check("fp0_p1", dataOut1, 32'h0);
        check("fp0_p2", dataOut2, 32'hf0f0f0f0);

        drive(0, 0, 1, 32'h12345678, 1, 2);
        tick;
        check("intkeep_p1", dataOut1, 32'h0000002c);
        check("intkeep_p2", dataOut2, 32'hffffffff);

        drive(1, 1, 31, 32'h33333333, 30, 31);
        tick;
        check("fp31_p1", dataOut1, 32'h0);
        check("fp31_p2", dataOut2, 32'h33333333);

        drive(1, 0, 31, 32'h55555555, 30, 31);
        tick;
        check("fp31hold_p2", dataOut2, 32'h33333333);

        // Asynchronous reset mid-cycle, with a write presented during it.
        #2 reset = 1'b1;
        #1;
        check("areset_fp31", dataOut2, 32'h0);
        drive(0, 1, 5, 32'haaaaaaaa, 1, 2);
        #1;
        check("areset_int1", dataOut1, 32'h0);
        check("areset_int2", dataOut2, 32'h0);
        tick;
        #2 reset = 1'b0;
        drive(0, 0, 0, 32'h0, 5, 1);
        #1;
        check("blocked_int5", dataOut1, 32'h0);
        check("cleared_int1", dataOut2, 32'h0);
        drive(1, 0, 0, 32'h0, 31, 1);
        #1;
        check("cleared_fp31", dataOut1, 32'h0);
        check("cleared_fp1", dataOut2, 32'h0);
        tick;

        // Randomized traffic; the negedge process checks every cycle.
        for (int n = 0; n < 600; n++) begin
            logic [4:0] wr;
            case ($urandom_range(0, 9))
                0:       wr = 5'd0;
                1:       wr = 5'd31;
                default: wr = 5'($urandom_range(0, 31));
            endcase
            drive(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), wr, $urandom,
                  5'($urandom_range(0, 31)), ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 79) == 0) begin
                #2 reset = 1'b1;
                tick;
                #2 reset = 1'b0;
            end else begin
                tick;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
